// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 receive path.
package hub75_pkg;

  localparam int unsigned RGB_R = 0;
  localparam int unsigned RGB_G = 1;
  localparam int unsigned RGB_B = 2;

  localparam int unsigned PX_X_W_MAX = 8;
  localparam int unsigned PX_Y_W_MAX = 8;

  typedef struct packed {
    logic [PX_X_W_MAX-1:0] x;
    logic [PX_Y_W_MAX-1:0] y;
    logic [2:0]            rgb0;
    logic [2:0]            rgb1;
    logic                  last;
  } px_beat_t;

  // Column index width; never narrower than one bit.
  function automatic int unsigned x_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/hub75_rx_sync.sv
// Single synchronizer chain for the whole HUB75 input bundle, plus
// rising-edge strobes for sclk and latch aligned with the synced data.
module hub75_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_BITS   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk_i,
  input  logic                 latch_i,
  input  logic                 blank_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [2:0]           rgb0_i,
  input  logic [2:0]           rgb1_i,
  output logic                 blank_o,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [2:0]           rgb0_o,
  output logic [2:0]           rgb1_o,
  output logic                 sclk_rise_c,
  output logic                 latch_rise_c
);

  localparam int unsigned BW = 3 + ADDR_BITS + 6;

  logic [BW-1:0] chain_q [SYNC_STAGES];
  logic          sclk_s;
  logic          latch_s;
  logic          sclk_prev_q;
  logic          latch_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain_q[i] <= '0;
      sclk_prev_q  <= 1'b0;
      latch_prev_q <= 1'b0;
    end else begin
      chain_q[0] <= {sclk_i, latch_i, blank_i, addr_i, rgb1_i, rgb0_i};
      for (int i = 1; i < SYNC_STAGES; i++) chain_q[i] <= chain_q[i-1];
      sclk_prev_q  <= sclk_s;
      latch_prev_q <= latch_s;
    end
  end

  assign {sclk_s, latch_s, blank_o, addr_o, rgb1_o, rgb0_o} = chain_q[SYNC_STAGES-1];
  assign sclk_rise_c  = sclk_s & ~sclk_prev_q;
  assign latch_rise_c = latch_s & ~latch_prev_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receiver: ping-pong line buffer filled on sclk, replayed as a pixel
// stream on latch. Optional blank on-time measurement: HUB75_RX_ONTIME_EN.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter  int unsigned WIDTH       = 64,
  parameter  int unsigned ADDR_BITS   = 5,
  parameter  int unsigned SYNC_STAGES = 2,
  localparam int unsigned XW          = x_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hub_sclk,
  input  logic                 hub_latch,
  input  logic                 hub_blank,
  input  logic [ADDR_BITS-1:0] hub_addr,
  input  logic [2:0]           hub_rgb0,
  input  logic [2:0]           hub_rgb1,
  output logic                 px_valid,
  input  logic                 px_ready,
  output logic [XW-1:0]        px_x,
  output logic [ADDR_BITS-1:0] px_y,
  output logic [2:0]           px_rgb0,
  output logic [2:0]           px_rgb1,
  output logic                 px_last,
  output logic                 frame_start,
  output logic                 overrun,
  input  logic                 ovr_clr
`ifdef HUB75_RX_ONTIME_EN
  ,
  output logic [15:0]          ontime,
  output logic                 ontime_valid
`endif
);

  localparam int unsigned KW = XW + 1;

  typedef enum logic {ST_IDLE, ST_DRAIN} state_e;

  logic                 blank_s;
  logic [ADDR_BITS-1:0] addr_s;
  logic [2:0]           rgb0_s, rgb1_s;
  logic                 sclk_rise, latch_rise;

  hub75_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .ADDR_BITS(ADDR_BITS)) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_i      (hub_sclk),
    .latch_i     (hub_latch),
    .blank_i     (hub_blank),
    .addr_i      (hub_addr),
    .rgb0_i      (hub_rgb0),
    .rgb1_i      (hub_rgb1),
    .blank_o     (blank_s),
    .addr_o      (addr_s),
    .rgb0_o      (rgb0_s),
    .rgb1_o      (rgb1_s),
    .sclk_rise_c (sclk_rise),
    .latch_rise_c(latch_rise)
  );

  logic [5:0]           mem_q [2][WIDTH];
  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d, n_q, n_d, n_lat;
  logic                 fill_q, fill_d;
  logic [ADDR_BITS-1:0] prev_q, prev_d, y_q, y_d;
  logic [XW-1:0]        x_q, x_d, idx;
  logic [2:0]           rgb0_q, rgb0_d, rgb1_q, rgb1_d;
  logic                 valid_q, valid_d, last_q, last_d;
  logic                 fs_q, fs_d, ovr_q, ovr_d;
  logic                 wr_en;
  logic [5:0]           rd_word;

  // Line buffer storage; emptiness is tracked by the counters, not the data.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[fill_q][k_q[XW-1:0]] <= {rgb1_s, rgb0_s};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      n_q     <= '0;
      fill_q  <= 1'b0;
      prev_q  <= '1;
      y_q     <= '0;
      x_q     <= '0;
      rgb0_q  <= '0;
      rgb1_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fs_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      fill_q  <= fill_d;
      prev_q  <= prev_d;
      y_q     <= y_d;
      x_q     <= x_d;
      rgb0_q  <= rgb0_d;
      rgb1_q  <= rgb1_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fs_q    <= fs_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    fill_d  = fill_q;
    prev_d  = prev_q;
    y_d     = y_q;
    x_d     = x_q;
    rgb0_d  = rgb0_q;
    rgb1_d  = rgb1_q;
    valid_d = valid_q;
    last_d  = last_q;
    fs_d    = 1'b0;
    ovr_d   = ovr_clr ? 1'b0 : ovr_q;
    wr_en   = 1'b0;
    idx     = '0;
    rd_word = '0;

    // Shift is applied before a coincident latch.
    if (sclk_rise) begin
      if (k_q == KW'(WIDTH)) begin
        ovr_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        k_d   = k_q + KW'(1);
      end
    end
    n_lat = k_d;
    if (latch_rise) k_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (latch_rise && n_lat != '0) begin
          // Rightmost pixel is the last one shifted; bypass a same-cycle write.
          rd_word = wr_en ? {rgb1_s, rgb0_s} : mem_q[fill_q][XW'(k_q - KW'(1))];
          state_d = ST_DRAIN;
          fill_d  = ~fill_q;
          n_d     = n_lat;
          valid_d = 1'b1;
          x_d     = '0;
          y_d     = addr_s;
          {rgb1_d, rgb0_d} = rd_word;
          last_d  = (n_lat == KW'(1));
          fs_d    = (addr_s <= prev_q);
          prev_d  = addr_s;
        end
      end
      ST_DRAIN: begin
        if (latch_rise && n_lat != '0) ovr_d = 1'b1;
        if (valid_q && px_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            idx     = XW'(n_q - KW'(x_q) - KW'(2));
            rd_word = mem_q[~fill_q][idx];
            x_d     = x_q + XW'(1);
            {rgb1_d, rgb0_d} = rd_word;
            last_d  = ((KW'(x_q) + KW'(2)) == n_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign px_valid    = valid_q;
  assign px_x        = x_q;
  assign px_y        = y_q;
  assign px_rgb0     = rgb0_q;
  assign px_rgb1     = rgb1_q;
  assign px_last     = last_q;
  assign frame_start = fs_q;
  assign overrun     = ovr_q;

`ifdef HUB75_RX_ONTIME_EN
  logic        blank_prev_q, ontime_valid_q;
  logic [15:0] cnt_q, ontime_q;

  // Lit-time counter captured on each blank rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_prev_q   <= 1'b0;
      cnt_q          <= '0;
      ontime_q       <= '0;
      ontime_valid_q <= 1'b0;
    end else begin
      blank_prev_q   <= blank_s;
      ontime_valid_q <= 1'b0;
      if (blank_s && !blank_prev_q) begin
        ontime_q       <= cnt_q;
        ontime_valid_q <= 1'b1;
        cnt_q          <= '0;
      end else if (!blank_s && cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign ontime       = ontime_q;
  assign ontime_valid = ontime_valid_q;
`else
  logic unused_blank;
  assign unused_blank = blank_s;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: line table, busy-overrun and reset sequences, random lines.
module tb_hub75_rx;
  import hub75_pkg::*;

  localparam int W  = 64;
  localparam int AB = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hub_sclk, hub_latch, hub_blank;
  logic [AB-1:0] hub_addr;
  logic [2:0]    hub_rgb0, hub_rgb1;
  logic          px_valid, px_ready, px_last, frame_start, overrun, ovr_clr;
  logic [5:0]    px_x;
  logic [AB-1:0] px_y;
  logic [2:0]    px_rgb0, px_rgb1;
`ifdef HUB75_RX_ONTIME_EN
  logic [15:0]   ontime;
  logic          ontime_valid;
`endif

  always #5 clk = ~clk;

  hub75_rx #(.WIDTH(W), .ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hub_sclk    (hub_sclk),
    .hub_latch   (hub_latch),
    .hub_blank   (hub_blank),
    .hub_addr    (hub_addr),
    .hub_rgb0    (hub_rgb0),
    .hub_rgb1    (hub_rgb1),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_x        (px_x),
    .px_y        (px_y),
    .px_rgb0     (px_rgb0),
    .px_rgb1     (px_rgb1),
    .px_last     (px_last),
    .frame_start (frame_start),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
`ifdef HUB75_RX_ONTIME_EN
    ,
    .ontime      (ontime),
    .ontime_valid(ontime_valid)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Ready driver: random or forced level, changes just after each rising edge.
  logic rdy_rand = 1'b0;
  logic rdy_val  = 1'b1;
  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      px_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Output monitor: collects accepted beats, counts frame_start, checks stall hold.
  px_beat_t got_q[$];
  int       fs_cnt = 0;
  px_beat_t held;
  logic     stalled = 1'b0;
  always @(negedge clk) begin
    px_beat_t cur;
    cur.x = 8'(px_x);
    cur.y = 8'(px_y);
    cur.rgb0 = px_rgb0;
    cur.rgb1 = px_rgb1;
    cur.last = px_last;
    if (rst_n && stalled) check("stall_hold", 64'({px_valid, cur}), 64'({1'b1, held}));
    stalled = rst_n && px_valid && !px_ready;
    held = cur;
    if (rst_n && px_valid && px_ready) got_q.push_back(cur);
    if (frame_start) fs_cnt++;
  end

  // Reference model: the samples shifted for the current line, oldest first.
  logic [5:0] samp[$];
  int         prev_addr = (1 << AB) - 1;

  function automatic bit model_fs(input int addr, input int n);
    bit fs;
    if (n == 0) return 1'b0;
    fs = (addr <= prev_addr);
    prev_addr = addr;
    return fs;
  endfunction

  task automatic pulse(input logic [2:0] r0, input logic [2:0] r1);
    hub_rgb0 = r0;
    hub_rgb1 = r1;
    tick(2);
    hub_sclk = 1'b1;
    tick(2);
    hub_sclk = 1'b0;
  endtask

  task automatic send_line(input int n, input bit pattern);
    logic [2:0] r0, r1;
    samp.delete();
    for (int k = 0; k < n; k++) begin
      r0 = pattern ? 3'(k) : 3'($urandom);
      r1 = 3'($urandom);
      samp.push_back({r1, r0});
      pulse(r0, r1);
    end
  endtask

  task automatic do_latch(input int addr);
    hub_addr = AB'(addr);
    tick(2);
    hub_latch = 1'b1;
    tick(2);
    hub_latch = 1'b0;
    tick(2);
  endtask

  task automatic clear_ovr();
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
  endtask

  // Expected line: beat j is the (N-1-j)th kept sample; extra samples are dropped.
  task automatic check_line(input int addr, input string nm);
    int       n;
    px_beat_t e;
    n = (samp.size() > W) ? W : samp.size();
    for (int c = 0; c < 4000 && got_q.size() < n; c++) tick(1);
    tick(10);
    check({nm, "_count"}, 64'(got_q.size()), 64'(n));
    for (int j = 0; j < n && j < got_q.size(); j++) begin
      e.x = 8'(j);
      e.y = 8'(addr);
      {e.rgb1, e.rgb0} = samp[n-1-j];
      e.last = (j == n - 1);
      check($sformatf("%s_beat%0d", nm, j), 64'(got_q[j]), 64'(e));
    end
    got_q.delete();
  endtask

  typedef struct {
    int n;
    int addr;
    bit pattern;
    bit rrdy;
    int exp_fs;
    bit exp_ovr;
  } row_t;

  row_t rows[10];

  initial begin
    logic [5:0] first_line[$];
    int         n, a;
    bit         efs;

    rows[0] = '{64,  5, 1'b1, 1'b0, 1, 1'b0};
    rows[1] = '{10,  7, 1'b0, 1'b1, 0, 1'b0};
    rows[2] = '{65,  8, 1'b0, 1'b1, 0, 1'b1};
    rows[3] = '{20, 30, 1'b0, 1'b1, 0, 1'b0};
    rows[4] = '{20, 31, 1'b0, 1'b1, 0, 1'b0};
    rows[5] = '{20,  0, 1'b0, 1'b1, 1, 1'b0};
    rows[6] = '{ 1,  0, 1'b0, 1'b0, 1, 1'b0};
    rows[7] = '{ 0,  3, 1'b0, 1'b0, 0, 1'b0};
    rows[8] = '{ 5,  2, 1'b0, 1'b1, 0, 1'b0};
    rows[9] = '{64,  2, 1'b0, 1'b1, 1, 1'b0};

    rst_n = 1'b0; hub_sclk = 1'b0; hub_latch = 1'b0; hub_blank = 1'b1;
    hub_addr = '0; hub_rgb0 = '0; hub_rgb1 = '0; ovr_clr = 1'b0;
    tick(3);
    check("reset_outputs", 64'({px_valid, px_x, px_y, px_rgb0, px_rgb1, px_last, frame_start, overrun}), 64'(0));
    rst_n = 1'b1;
    tick(5);

    foreach (rows[i]) begin
      clear_ovr();
      fs_cnt = 0;
      rdy_rand = rows[i].rrdy;
      rdy_val = 1'b1;
      send_line(rows[i].n, rows[i].pattern);
      do_latch(rows[i].addr);
      efs = model_fs(rows[i].addr, rows[i].n);
      check_line(rows[i].addr, $sformatf("row%0d", i));
      check($sformatf("row%0d_frame_start", i), 64'(fs_cnt), 64'(rows[i].exp_fs));
      check($sformatf("row%0d_overrun", i), 64'(overrun), 64'(rows[i].exp_ovr));
    end

    // Second line while the first is stalled: dropped, overrun set, output held.
    clear_ovr();
    fs_cnt = 0;
    rdy_rand = 1'b0;
    rdy_val = 1'b0;
    send_line(8, 1'b0);
    first_line = samp;
    do_latch(4);
    efs = model_fs(4, 8);
    for (int c = 0; c < 50 && !px_valid; c++) tick(1);
    check("busy_valid", 64'(px_valid), 64'(1));
    check("busy_ovr_before", 64'(overrun), 64'(0));
    send_line(W, 1'b0);
    do_latch(9);
    check("busy_ovr_set", 64'(overrun), 64'(1));
    check("busy_head_beat", 64'({px_valid, px_x, px_y, px_rgb1, px_rgb0, px_last}),
          64'({1'b1, 6'd0, AB'(4), first_line[7], 1'b0}));
    clear_ovr();
    check("busy_ovr_clr", 64'(overrun), 64'(0));
    samp = first_line;
    rdy_val = 1'b1;
    check_line(4, "busy_line");
    check("busy_frame_start", 64'(fs_cnt), 64'(efs));

    // Random lines against the model with random backpressure.
    rdy_rand = 1'b1;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, W);
      a = $urandom_range(0, (1 << AB) - 1);
      fs_cnt = 0;
      send_line(n, 1'b0);
      do_latch(a);
      efs = model_fs(a, n);
      check_line(a, $sformatf("rand%0d", t));
      check($sformatf("rand%0d_frame_start", t), 64'(fs_cnt), 64'(efs));
      check($sformatf("rand%0d_overrun", t), 64'(overrun), 64'(0));
    end
    rdy_rand = 1'b0;

`ifdef HUB75_RX_ONTIME_EN
    begin
      bit seen;
      seen = 1'b0;
      hub_blank = 1'b0;
      tick(100);
      hub_blank = 1'b1;
      for (int c = 0; c < 12 && !seen; c++) begin
        @(negedge clk);
        if (ontime_valid) begin
          seen = 1'b1;
          check("ontime_range", 64'(ontime >= 16'd99 && ontime <= 16'd101), 64'(1));
        end
      end
      check("ontime_valid_seen", 64'(seen), 64'(1));
      @(negedge clk);
      check("ontime_valid_pulse", 64'(ontime_valid), 64'(0));
    end
`endif

    // Reset asserted mid-drain clears the stream at once.
    rdy_val = 1'b0;
    send_line(4, 1'b0);
    do_latch(1);
    for (int c = 0; c < 50 && !px_valid; c++) tick(1);
    check("middrain_valid", 64'(px_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("middrain_reset", 64'({px_valid, px_last, frame_start, overrun}), 64'(0));
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
